// File: rtl/opcode_sequencer.sv
// opcode_sequencer
//   Sits between fetch and decode/control. It passes fetched opcodes through
//   with one cycle of latency, expands CALL/RET/RTI into two consecutive
//   opcodes, and injects the two-opcode interrupt entry sequence
//   (11110, 11111) when an interrupt request is pending.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   fetchOpCode  : opcode field of the instruction presented by fetch
//   fetchValid   : fetchOpCode is meaningful this cycle
//   intReq       : one-cycle external interrupt request pulse
//   stall        : hazard freeze; holds the sequencer and injects a bubble
//   opCode       : registered opcode to decode/control
//   makeMeBubble : registered bubble flag to control
//   pcHold       : combinational; fetch re-presents the same instruction
//   seqBusy      : combinational; sequencer is not in IDLE
module opcode_sequencer #(
  parameter int unsigned OPW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] fetchOpCode,
  input  logic           fetchValid,
  input  logic           intReq,
  input  logic           stall,
  output logic [OPW-1:0] opCode,
  output logic           makeMeBubble,
  output logic           pcHold,
  output logic           seqBusy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    INT1   = 2'd2,
    INT2   = 2'd3
  } seqStateT;

  localparam logic [OPW-1:0] opNop  = OPW'(5'b00000);
  localparam logic [OPW-1:0] opCall = OPW'(5'b11000);
  localparam logic [OPW-1:0] opRet  = OPW'(5'b11010);
  localparam logic [OPW-1:0] opRti  = OPW'(5'b11100);
  localparam logic [OPW-1:0] opInt1 = OPW'(5'b11110);
  localparam logic [OPW-1:0] opInt2 = OPW'(5'b11111);

  seqStateT       state, stateNext;
  logic [OPW-1:0] opCodeNext;
  logic [OPW-1:0] second, secondNext;
  logic           intPending, intPendingNext;
  logic           bubbleNext;
  logic           isTwoPart;
  logic           intSet;

  assign isTwoPart = (fetchOpCode == opCall) || (fetchOpCode == opRet) ||
                     (fetchOpCode == opRti);

  // Requests are captured only outside the interrupt entry sequence.
  assign intSet = intReq && ((state == IDLE) || (state == SECOND));

  assign pcHold  = stall || (state == SECOND) || (state == INT1) ||
                   ((state == IDLE) && intPending);
  assign seqBusy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      opCode       <= '0;
      makeMeBubble <= 1'b1;
      intPending   <= 1'b0;
      second       <= '0;
    end else begin
      state        <= stateNext;
      opCode       <= opCodeNext;
      makeMeBubble <= bubbleNext;
      intPending   <= intPendingNext;
      second       <= secondNext;
    end
  end

  always_comb begin
    stateNext      = state;
    opCodeNext     = opCode;
    secondNext     = second;
    intPendingNext = intPending;
    bubbleNext     = stall;

    if (!stall) begin
      unique case (state)
        // INT2 exits through the normal IDLE rules so the instruction held
        // at fetch during the interrupt sequence is consumed on this edge.
        IDLE, INT2: begin
          if (intPending) begin
            opCodeNext     = opInt1;
            stateNext      = INT1;
            intPendingNext = 1'b0;
          end else if (fetchValid) begin
            opCodeNext = fetchOpCode;
            if (isTwoPart) begin
              stateNext  = SECOND;
              secondNext = fetchOpCode + OPW'(1);
            end else begin
              stateNext = IDLE;
            end
          end else begin
            opCodeNext = opNop;
            stateNext  = IDLE;
          end
        end
        SECOND: begin
          opCodeNext = second;
          stateNext  = IDLE;
        end
        INT1: begin
          opCodeNext = opInt2;
          stateNext  = INT2;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end

    // A new request wins over the clear of a request being taken this edge.
    if (intSet) begin
      intPendingNext = 1'b1;
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
module tb_opcode_sequencer;

  typedef struct {
    logic       fv;
    logic [4:0] fop;
    logic       ir;
    logic       st;
    logic       hold;   // expected pcHold before the edge
    logic       busy;   // expected seqBusy before the edge
    logic [4:0] op;     // expected opCode after the edge
    logic       bub;    // expected makeMeBubble after the edge
  } vecT;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] fetchOpCode;
  logic       fetchValid;
  logic       intReq;
  logic       stall;
  logic [4:0] opCode;
  logic       makeMeBubble;
  logic       pcHold;
  logic       seqBusy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  vecT vecs[$];

  opcode_sequencer #(.OPW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetchOpCode  (fetchOpCode),
    .fetchValid   (fetchValid),
    .intReq       (intReq),
    .stall        (stall),
    .opCode       (opCode),
    .makeMeBubble (makeMeBubble),
    .pcHold       (pcHold),
    .seqBusy      (seqBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic fv, input logic [4:0] fop, input logic ir, input logic st,
                     input logic hold, input logic busy, input logic [4:0] op, input logic bub);
    vecT v;
    v.fv = fv; v.fop = fop; v.ir = ir; v.st = st;
    v.hold = hold; v.busy = busy; v.op = op; v.bub = bub;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fv, input logic [4:0] fop, input logic ir, input logic st);
    fetchValid = fv; fetchOpCode = fop; intReq = ir; stall = st;
  endtask

  // Called at posedge+1: drive, check comb outputs, clock, check registers.
  task automatic step(input string tag, input vecT v);
    drive(v.fv, v.fop, v.ir, v.st);
    #2;
    chk({tag, ".pcHold"}, 32'(pcHold), 32'(v.hold));
    chk({tag, ".seqBusy"}, 32'(seqBusy), 32'(v.busy));
    @(posedge clk);
    #1;
    chk({tag, ".opCode"}, 32'(opCode), 32'(v.op));
    chk({tag, ".bubble"}, 32'(makeMeBubble), 32'(v.bub));
  endtask

  initial begin
    //   fv    fop       ir st   hold busy op        bub
    // plain stream
    add(1, 5'b01001, 0, 0,   0, 0, 5'b01001, 0);
    add(1, 5'b00100, 0, 0,   0, 0, 5'b00100, 0);
    // CALL expansion
    add(1, 5'b11000, 0, 0,   0, 0, 5'b11000, 0);
    add(1, 5'b01001, 0, 0,   1, 1, 5'b11001, 0);
    add(1, 5'b01001, 0, 0,   0, 0, 5'b01001, 0);
    // interrupt from IDLE
    add(0, 5'b00000, 1, 0,   0, 0, 5'b00000, 0);
    add(1, 5'b01010, 0, 0,   1, 0, 5'b11110, 0);
    add(1, 5'b01010, 0, 0,   1, 1, 5'b11111, 0);
    add(1, 5'b01010, 0, 0,   0, 1, 5'b01010, 0);
    // intReq together with RET
    add(1, 5'b11010, 1, 0,   0, 0, 5'b11010, 0);
    add(1, 5'b00111, 0, 0,   1, 1, 5'b11011, 0);
    add(1, 5'b00111, 0, 0,   1, 0, 5'b11110, 0);
    add(1, 5'b00111, 0, 0,   1, 1, 5'b11111, 0);
    add(1, 5'b00111, 0, 0,   0, 1, 5'b00111, 0);
    // stall while in SECOND after RTI
    add(1, 5'b11100, 0, 0,   0, 0, 5'b11100, 0);
    add(1, 5'b00001, 0, 1,   1, 1, 5'b11100, 1);
    add(1, 5'b00001, 0, 1,   1, 1, 5'b11100, 1);
    add(1, 5'b00001, 0, 0,   1, 1, 5'b11101, 0);
    add(1, 5'b00001, 0, 0,   0, 0, 5'b00001, 0);
    // pass-through opcodes
    add(1, 5'b11001, 0, 0,   0, 0, 5'b11001, 0);
    add(1, 5'b11110, 0, 0,   0, 0, 5'b11110, 0);
    add(1, 5'b11111, 0, 0,   0, 0, 5'b11111, 0);
    add(1, 5'b11011, 0, 0,   0, 0, 5'b11011, 0);
    add(1, 5'b11101, 0, 0,   0, 0, 5'b11101, 0);
    add(1, 5'b00010, 0, 0,   0, 0, 5'b00010, 0);
    // intReq in SECOND waits for the pair; intReq ignored in INT1/INT2
    add(1, 5'b11000, 0, 0,   0, 0, 5'b11000, 0);
    add(1, 5'b00011, 1, 0,   1, 1, 5'b11001, 0);
    add(1, 5'b00011, 0, 0,   1, 0, 5'b11110, 0);
    add(1, 5'b00011, 1, 0,   1, 1, 5'b11111, 0);
    add(1, 5'b00011, 1, 0,   0, 1, 5'b00011, 0);
    add(1, 5'b00011, 0, 0,   0, 0, 5'b00011, 0);
    // stall in IDLE, then stall with an interrupt arriving
    add(1, 5'b00101, 0, 1,   1, 0, 5'b00011, 1);
    add(1, 5'b00101, 0, 0,   0, 0, 5'b00101, 0);
    add(1, 5'b01100, 1, 1,   1, 0, 5'b00101, 1);
    add(1, 5'b01100, 0, 0,   1, 0, 5'b11110, 0);
    add(1, 5'b01100, 0, 0,   1, 1, 5'b11111, 0);
    add(1, 5'b01100, 0, 0,   0, 1, 5'b01100, 0);
    // two-part opcode consumed on the INT2 exit edge
    add(0, 5'b00000, 1, 0,   0, 0, 5'b00000, 0);
    add(1, 5'b11000, 0, 0,   1, 0, 5'b11110, 0);
    add(1, 5'b11000, 0, 0,   1, 1, 5'b11111, 0);
    add(1, 5'b11000, 0, 0,   0, 1, 5'b11000, 0);
    add(1, 5'b00000, 0, 0,   1, 1, 5'b11001, 0);
    add(0, 5'b00000, 0, 0,   0, 0, 5'b00000, 0);

    // reset state
    rst = 1'b0;
    drive(0, 5'b00000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.opCode", 32'(opCode), 32'h00);
    chk("rst.bubble", 32'(makeMeBubble), 32'h1);
    chk("rst.seqBusy", 32'(seqBusy), 32'h0);
    chk("rst.pcHold", 32'(pcHold), 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

    // asynchronous reset while in INT1: no 11111 afterwards
    begin
      vecT v;
      v = '{fv:1'b0, fop:5'b00000, ir:1'b1, st:1'b0, hold:1'b0, busy:1'b0, op:5'b00000, bub:1'b0};
      step("int1a", v);
      v = '{fv:1'b1, fop:5'b01101, ir:1'b0, st:1'b0, hold:1'b1, busy:1'b0, op:5'b11110, bub:1'b0};
      step("int1b", v);
      #2;
      rst = 1'b0;
      #1;
      chk("arst.opCode", 32'(opCode), 32'h00);
      chk("arst.bubble", 32'(makeMeBubble), 32'h1);
      chk("arst.seqBusy", 32'(seqBusy), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      v = '{fv:1'b1, fop:5'b01101, ir:1'b0, st:1'b0, hold:1'b0, busy:1'b0, op:5'b01101, bub:1'b0};
      step("postInt1", v);

      // reset while in SECOND: second part abandoned
      v = '{fv:1'b1, fop:5'b11010, ir:1'b0, st:1'b0, hold:1'b0, busy:1'b0, op:5'b11010, bub:1'b0};
      step("sec", v);
      chk("sec.busy", 32'(seqBusy), 32'h1);
      rst = 1'b0;
      #1;
      chk("arst2.opCode", 32'(opCode), 32'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      v = '{fv:1'b1, fop:5'b00110, ir:1'b0, st:1'b0, hold:1'b0, busy:1'b0, op:5'b00110, bub:1'b0};
      step("postSec", v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opcode_sequencer.md
OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001: Parameter OPW, default 5, is the opcode width.
REQ-002: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003: rst, input, 1 bit; reset is asynchronous and active-low.
REQ-004: fetchOpCode, input, OPW bits, the opcode field of the instruction currently presented by fetch.
REQ-005: fetchValid, input, 1 bit; fetchOpCode is meaningful this cycle.
REQ-006: intReq, input, 1 bit, a one-cycle external interrupt request pulse.
REQ-007: stall, input, 1 bit, a hazard-unit request to freeze the sequencer and inject a bubble.
REQ-008: opCode, output, OPW bits, registered opcode driven to the decode/control unit.
REQ-009: makeMeBubble, output, 1 bit, registered bubble flag to the control unit.
REQ-010: pcHold, output, 1 bit, combinational; fetch shall re-present the same instruction next cycle.
REQ-011: seqBusy, output, 1 bit, combinational; high when the state is not IDLE.

Function
REQ-012: The FSM states shall be IDLE, SECOND, INT1 and INT2, held in a 2-bit state register.
REQ-013: intPending is a 1-bit register, set on any cycle with intReq=1 while the state is IDLE or SECOND.
REQ-014: intReq shall be ignored while the state is INT1 or INT2.
REQ-015: Any clock edge with stall=1 shall:
- hold state, intPending-clear and opCode;
- set makeMeBubble<=1;
- still allow intPending to be set per REQ-013.
REQ-016: Any clock edge with stall=0 shall set makeMeBubble<=0.
REQ-017: When IDLE, stall=0 and intPending=1, the next edge shall:
- set opCode<=5'b11110;
- move the state to INT1;
- clear intPending.
The fetched opcode is not consumed.
REQ-018: When IDLE, stall=0, intPending=0 and fetchValid=1, opCode<=fetchOpCode.
REQ-019: In the REQ-018 case, if fetchOpCode is 11000 (CALL), 11010 (RET) or 11100 (RTI), the state shall move to SECOND and register second=fetchOpCode+1.
REQ-020: When IDLE, stall=0, intPending=0 and fetchValid=0, opCode<=5'b00000 and the state stays IDLE.
REQ-021: From SECOND with stall=0, the next edge shall set opCode<=second (11001, 11011 or 11101) and return the state to IDLE.
REQ-022: From INT1 with stall=0, the next edge shall set opCode<=5'b11111 and move the state to INT2.
REQ-023: From INT2 with stall=0, the next edge shall set opCode per REQ-017 to REQ-020, evaluated as if the state were IDLE, and leave the state per those rules.
REQ-024: pcHold shall be asserted when any of the following holds:
- stall=1;
- the state is SECOND;
- the state is INT1;
- the state is IDLE and intPending=1.
REQ-025: pcHold shall be 0 in INT2, so the instruction presented during INT2 is consumed on the exit edge.
REQ-026: Latency shall be one cycle from a fetchOpCode being accepted to it appearing on opCode.
REQ-027: A second-part opcode shall appear on the cycle immediately after its first part, except for stall cycles.
REQ-028: An interrupt arriving during a two-part instruction shall be taken only after the second part has issued; a two-part pair is never split.
REQ-029: Opcodes 11001, 11011, 11101, 11110 and 11111 presented by fetch shall be passed through unchanged with no state change.

Reset
REQ-030: While rst=0, the block shall hold:
- state=IDLE;
- opCode=5'b00000;
- makeMeBubble=1;
- intPending=0;
- second=5'b00000.
REQ-031: Reset asserted mid-sequence (SECOND, INT1 or INT2) shall abandon the sequence; no second part is issued after release.
REQ-032: On the first edge after rst rises, normal IDLE rules shall apply.

Verification
REQ-033: Reset, then fetchValid=1 with the stream 01001, 00100 -> opCode 01001 then 00100 one cycle later; pcHold=0; makeMeBubble=0 after the first edge.
REQ-034: CALL 11000, followed by fetch presenting 01001 -> opCode 11000, then 11001 with pcHold=1 and seqBusy=1, then 01001.
REQ-035: intReq pulse in IDLE while fetch presents 01010 -> opCode 11110, then 11111, then 01010; pcHold=1 for the two cycles before INT2; intPending cleared.
REQ-036: intReq on the same cycle RET 11010 is accepted -> opCode 11010, 11011, 11110, 11111, then the next fetched opcode.
REQ-037: stall=1 for 2 cycles while in SECOND after RTI 11100 -> makeMeBubble=1 for 2 cycles, opCode held at 11100, pcHold=1; then 11101 issues.
REQ-038: rst pulsed low while in INT1 -> opCode=00000 and makeMeBubble=1 immediately (asynchronously); no 11111 follows after release.
